program_loader: RTL and testbench

//  Sequences the UART receive path at boot. Consumes assembled 32-bit words

---
 rtl/program_loader.sv | 184 ++++++++++++++++++
 tb/tb_program_loader.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// program_loader
//   Boot-time sequencer for the UART receive path. Takes 32-bit words from the
//   byte-to-word receiver buffer and parses one frame:
//     header N, then N payload words, then one checksum word (XOR of the payload).
//   Payload words go to instruction memory starting at BASE_ADDR. The address
//   wraps modulo 2**ADDR_W. A matching checksum releases the CPU. A bad checksum,
//   an oversized header or an inter-word timeout parks the loader in ERROR.
//
// Ports
//   CLK           system clock, all logic on posedge
//   reset         asynchronous, active-low reset
//   rx_word       assembled word from the receiver buffer
//   rx_ready      receiver-buffer word flag (level)
//   restart       synchronous abort/re-arm, returns to IDLE from any state
//   imem_we       instruction memory write enable (1-cycle pulse per word)
//   imem_addr     instruction memory write address
//   imem_wdata    instruction memory write data
//   loading       high in LOAD and CHECK
//   cpu_start     1-cycle pulse on entry to DONE
//   cpu_run       high while in DONE
//   load_error    high while in ERROR
//   words_loaded  payload words written so far
//   dbg_state     current FSM state, for debug and checkers
//
// Handshake: rx_ready is a level flag that may stay high for several cycles.
// A word is taken only on the cycle where rx_ready rises (rx_ready=1, previous
// cycle 0). The word is sampled in that cycle, and a held-high flag is never
// taken twice. There is no back-pressure toward the receiver buffer.

module program_loader #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0,
  parameter logic [31:0] TIMEOUT   = 32'd100000
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic [31:0]       rx_word,
  input  logic              rx_ready,
  input  logic              restart,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              loading,
  output logic              cpu_start,
  output logic              cpu_run,
  output logic              load_error,
  output logic [ADDR_W:0]   words_loaded,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CHECK = 3'd2,
    S_DONE  = 3'd3,
    S_ERROR = 3'd4
  } state_e;

  localparam logic [31:0]       MAX_N = 32'd1 << ADDR_W;
  localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);

  state_e              state_q, state_d;
  logic                ready_q;
  logic [ADDR_W:0]     n_q, n_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [31:0]         csum_q, csum_d;
  logic [31:0]         timer_q, timer_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                start_q, start_d;

  logic                accept;
  logic [ADDR_W:0]     count_inc;
  logic                timeout_hit;

  assign accept      = rx_ready & ~ready_q;
  assign count_inc   = count_q + {{ADDR_W{1'b0}}, 1'b1};
  assign timeout_hit = (TIMEOUT != 32'd0) && (timer_q == TIMEOUT);

  // State and datapath registers
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ready_q <= 1'b0;
      n_q     <= '0;
      count_q <= '0;
      csum_q  <= '0;
      timer_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= rx_ready;
      n_q     <= n_d;
      count_q <= count_d;
      csum_q  <= csum_d;
      timer_q <= timer_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      start_q <= start_d;
    end
  end

  // Next-state logic. Restart overrides any accept or timeout in the same cycle.
  always_comb begin
    state_d = state_q;
    if (restart) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (rx_word > MAX_N)      state_d = S_ERROR;
            else if (rx_word == '0)   state_d = S_CHECK;
            else                      state_d = S_LOAD;
          end
        end
        S_LOAD: begin
          if (accept) begin
            if (count_inc == n_q) state_d = S_CHECK;
          end else if (timeout_hit) begin
            state_d = S_ERROR;
          end
        end
        S_CHECK: begin
          if (accept)           state_d = (rx_word == csum_q) ? S_DONE : S_ERROR;
          else if (timeout_hit) state_d = S_ERROR;
        end
        default: state_d = state_q;
      endcase
    end
  end

  // Datapath next values
  always_comb begin
    n_d     = n_q;
    count_d = count_q;
    csum_d  = csum_q;
    timer_d = timer_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    start_d = (state_d == S_DONE) && (state_q != S_DONE);
    if (restart) begin
      count_d = '0;
      csum_d  = '0;
      timer_d = '0;
    end else begin
      if (state_q == S_LOAD || state_q == S_CHECK) timer_d = timer_q + 32'd1;
      // The timer restarts on every taken word and whenever a new state is entered.
      if (accept || (state_d != state_q)) timer_d = '0;
      if (state_q == S_IDLE && accept) begin
        n_d     = rx_word[ADDR_W:0];
        count_d = '0;
        csum_d  = '0;
      end
      if (state_q == S_LOAD && accept) begin
        we_d    = 1'b1;
        addr_d  = BASE + count_q[ADDR_W-1:0];
        wdata_d = rx_word;
        count_d = count_inc;
        csum_d  = csum_q ^ rx_word;
      end
    end
  end

  // Outputs
  always_comb begin
    imem_we      = we_q;
    imem_addr    = addr_q;
    imem_wdata   = wdata_q;
    loading      = (state_q == S_LOAD) || (state_q == S_CHECK);
    cpu_start    = start_q;
    cpu_run      = (state_q == S_DONE);
    load_error   = (state_q == S_ERROR);
    words_loaded = count_q;
    dbg_state    = state_q;
  end

endmodule

// File: tb/tb_program_loader.sv
// Testbench for program_loader. It uses a small memory (ADDR_W=4) and a base
// near the top (BASE_ADDR=12), so that frames wrap past the top address. A short
// TIMEOUT of 50 cycles keeps the timeout case fast.
module tb_program_loader;
  localparam int AW   = 4;
  localparam int BASE = 12;
  localparam int W    = AW + 32;

  logic          CLK;
  logic          reset;
  logic [31:0]   rx_word;
  logic          rx_ready;
  logic          restart;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          loading;
  logic          cpu_start;
  logic          cpu_run;
  logic          load_error;
  logic [AW:0]   words_loaded;
  logic [2:0]    dbg_state;

  program_loader #(.ADDR_W(AW), .BASE_ADDR(BASE), .TIMEOUT(32'd50)) dut (
    .CLK(CLK), .reset(reset), .rx_word(rx_word), .rx_ready(rx_ready),
    .restart(restart), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .loading(loading), .cpu_start(cpu_start),
    .cpu_run(cpu_run), .load_error(load_error), .words_loaded(words_loaded),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errs = 0;
  int start_cnt = 0;
  logic prev_we = 1'b0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_e;
  logic [31:0]  pay[0:15];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // scoreboard: every write must match the next expected (addr, data)
  always @(negedge CLK) begin
    if (imem_we) begin
      if (exp_q.size() == 0) begin
        check("spurious_write", 64'(imem_addr), 64'hFFFF);
      end else begin
        exp_e = exp_q.pop_front();
        check("wr_addr", 64'(imem_addr), 64'(exp_e[W-1:32]));
        check("wr_data", 64'(imem_wdata), 64'(exp_e[31:0]));
      end
      check("we_back_to_back", 64'(prev_we), 64'd0);
    end
    if (cpu_start) start_cnt++;
    prev_we = imem_we;
  end

  // reference: XOR of the payload, and wrapped payload addresses
  function automatic logic [31:0] frame_csum(input int n);
    logic [31:0] x = 32'd0;
    for (int i = 0; i < n; i++) x ^= pay[i];
    return x;
  endfunction

  function automatic logic [AW-1:0] payload_addr(input int i);
    return AW'((BASE + i) % (1 << AW));
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_we"},      64'(imem_we), 0);
    check({tag, "_loading"}, 64'(loading), 0);
    check({tag, "_start"},   64'(cpu_start), 0);
    check({tag, "_run"},     64'(cpu_run), 0);
    check({tag, "_err"},     64'(load_error), 0);
    check({tag, "_words"},   64'(words_loaded), 0);
  endtask

  // driver: raise rx_ready with a word, hold it, then drop it and idle for gap cycles
  task automatic send_word(input logic [31:0] w, input int hold, input int gap,
                           input logic exp_we, input logic exp_start);
    @(negedge CLK);
    rx_word  = w;
    rx_ready = 1'b1;
    @(posedge CLK); #1;
    check("we_latency", 64'(imem_we), 64'(exp_we));
    check("start_latency", 64'(cpu_start), 64'(exp_start));
    for (int i = 1; i < hold; i++) begin
      @(posedge CLK); #1;
      check("we_during_hold", 64'(imem_we), 0);
    end
    @(negedge CLK);
    rx_ready = 1'b0;
    repeat (gap) @(negedge CLK);
  endtask

  task automatic do_restart();
    @(negedge CLK);
    restart = 1'b1;
    @(negedge CLK);
    restart = 1'b0;
    check_idle_outputs("restart");
  endtask

  task automatic run_frame(input int n, input logic [31:0] cs, input int hold, input int gap);
    logic good;
    int   st0;
    good = (cs == frame_csum(n));
    st0  = start_cnt;
    send_word(32'(n), hold, gap, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({payload_addr(i), pay[i]});
      send_word(pay[i], hold, gap, 1'b1, 1'b0);
    end
    send_word(cs, hold, gap, 1'b0, good);
    repeat (3) @(negedge CLK);
    check("frame_run",     64'(cpu_run), 64'(good));
    check("frame_err",     64'(load_error), 64'(!good));
    check("frame_words",   64'(words_loaded), 64'(n));
    check("frame_loading", 64'(loading), 0);
    check("frame_starts",  64'(start_cnt - st0), 64'(good));
    check("frame_pending", 64'(exp_q.size()), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Result: errors=%0d of %0d checks", errs + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    reset    = 1'b0;
    rx_word  = 32'd0;
    rx_ready = 1'b0;
    restart  = 1'b0;
    repeat (3) @(negedge CLK);
    check_idle_outputs("reset");
    check("reset_addr",  64'(imem_addr), 0);
    check("reset_wdata", 64'(imem_wdata), 0);
    reset = 1'b1;
    repeat (2) @(negedge CLK);

    // N=3 frame, good checksum, about 16 cycles between words
    pay[0] = 32'h11; pay[1] = 32'h22; pay[2] = 32'h44;
    run_frame(3, 32'h77, 1, 14);
    do_restart();

    // same frame, bad checksum
    run_frame(3, 32'h76, 1, 14);
    do_restart();

    // empty frame
    run_frame(0, 32'h0, 1, 2);
    do_restart();

    // oversized header goes to ERROR on the accept edge
    send_word(32'd17, 1, 2, 1'b0, 1'b0);
    check("oversize_err", 64'(load_error), 1);
    check("oversize_loading", 64'(loading), 0);
    do_restart();

    // largest frame (N=16) wraps past the top address; rx_ready held for 5 cycles
    for (int i = 0; i < 16; i++) pay[i] = $urandom;
    run_frame(16, frame_csum(16), 5, 2);
    do_restart();

    // randomized frames
    for (int f = 0; f < 10; f++) begin
      int n;
      logic [31:0] cs;
      n = $urandom_range(0, 16);
      for (int i = 0; i < 16; i++) pay[i] = $urandom;
      cs = frame_csum(n);
      if ($urandom_range(0, 3) == 0) cs ^= (32'd1 << $urandom_range(0, 31));
      run_frame(n, cs, $urandom_range(1, 5), $urandom_range(0, 8));
      do_restart();
    end

    // timeout: N=4, stop after 2 payload words
    pay[0] = 32'hA5A5_0001; pay[1] = 32'h5A5A_0002;
    send_word(32'd4, 1, 1, 1'b0, 1'b0);
    exp_q.push_back({payload_addr(0), pay[0]});
    send_word(pay[0], 1, 1, 1'b1, 1'b0);
    exp_q.push_back({payload_addr(1), pay[1]});
    @(negedge CLK);
    rx_word = pay[1];
    rx_ready = 1'b1;
    @(posedge CLK); #1;
    check("to_we", 64'(imem_we), 1);
    cyc = 0;
    do begin
      @(posedge CLK); #1;
      cyc++;
    end while (!load_error && cyc < 200);
    check("to_cycles", 64'(cyc), 64'd51);
    check("to_words", 64'(words_loaded), 64'd2);
    check("to_pending", 64'(exp_q.size()), 0);
    rx_ready = 1'b0;
    do_restart();

    // restart in the same cycle as the 2nd payload edge drops that word
    pay[0] = 32'hCAFE_0001;
    send_word(32'd3, 1, 1, 1'b0, 1'b0);
    exp_q.push_back({payload_addr(0), pay[0]});
    send_word(pay[0], 1, 1, 1'b1, 1'b0);
    @(negedge CLK);
    rx_word  = 32'hDEAD_BEEF;
    rx_ready = 1'b1;
    restart  = 1'b1;
    @(posedge CLK); #1;
    check("rs_we", 64'(imem_we), 0);
    check("rs_loading", 64'(loading), 0);
    check("rs_words", 64'(words_loaded), 0);
    @(negedge CLK);
    restart  = 1'b0;
    rx_ready = 1'b0;
    @(negedge CLK);
    for (int i = 0; i < 2; i++) pay[i] = $urandom;
    run_frame(2, frame_csum(2), 1, 1);
    do_restart();

    // async reset mid-LOAD
    send_word(32'd5, 1, 1, 1'b0, 1'b0);
    @(negedge CLK);
    rx_word  = 32'h1234_5678;
    rx_ready = 1'b1;
    @(posedge CLK); #1;
    check("ar_we_before", 64'(imem_we), 1);
    reset = 1'b0;
    #1;
    check_idle_outputs("async_rst");
    check("async_rst_addr", 64'(imem_addr), 0);
    check("async_rst_wdata", 64'(imem_wdata), 0);
    rx_ready = 1'b0;
    @(negedge CLK);
    reset = 1'b1;
    @(negedge CLK);
    for (int i = 0; i < 3; i++) pay[i] = $urandom;
    run_frame(3, frame_csum(3), 2, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
